// File: rtl/decade_counter_sequencer.sv
// Single-clock BCD decade counter chain with preset, terminal-limit compare and
// an IDLE/RUN/PAUSE/DONE sequencer driven by prioritised panel commands.
module decade_counter_sequencer #(
  parameter int unsigned DIGITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic [4*DIGITS-1:0] limit,
  input  logic                up_dn,
  input  logic                auto_reload,
  output logic [4*DIGITS-1:0] count,
  output logic [1:0]          state,
  output logic                busy,
  output logic                done,
  output logic                carry_out
);

  localparam int unsigned W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   preset_q, preset_d;
  logic           done_q, done_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   stepped;
  logic           wrap;

  // Clamp any non-decimal digit to 9 so the chain never holds invalid BCD.
  function automatic logic [W-1:0] bcd_sat(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [3:0]   d;
    r = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      r[4*i +: 4] = (d > 4'd9) ? 4'd9 : d;
    end
    return r;
  endfunction

  // Returns {full_scale_wrap, next_value}.
  function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  function automatic logic [W:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return {b, r};
  endfunction

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    preset_d = preset_q;
    done_d   = 1'b0;
    carry_d  = 1'b0;
    {wrap, stepped} = up_dn ? bcd_inc(count_q) : bcd_dec(count_q);

    if (clear) begin
      count_d = '0;
      state_d = IDLE;
    end else if (load) begin
      preset_d = bcd_sat(load_val);
      count_d  = bcd_sat(load_val);
    end else if (stop) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (start) begin
      case (state_q)
        IDLE, PAUSE: state_d = RUN;
        DONE: begin
          state_d = RUN;
          count_d = preset_q;
        end
        default: ;
      endcase
    end else if (state_q == RUN) begin
      // Count is always valid BCD, so a limit with a digit > 9 can never match.
      if (count_q == limit) begin
        done_d = 1'b1;
        if (auto_reload) count_d = preset_q;
        else             state_d = DONE;
      end else begin
        count_d = stepped;
        carry_d = wrap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      preset_q <= '0;
      done_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      preset_q <= preset_d;
      done_q   <= done_d;
      carry_q  <= carry_d;
    end
  end

  assign count     = count_q;
  assign state     = state_q;
  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign carry_out = carry_q;

endmodule
